// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: drives one row low at a time, samples columns,
// and debounces whole-scan results into a key code, valid strobe and held flag.
module keypad_scanner #(
  parameter int ROW_HOLD       = 2,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk_1kHz,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi_err
);

  localparam int HW = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_HOLD - 1);
  localparam logic [CW-1:0] DS        = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_e;

  logic          active_q;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    code_q, code_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic          multi_err_q, multi_err_d;

  logic          sample, scan_end;
  logic [2:0]    nlow, hits_sum;
  logic [1:0]    low_col, hits_new;
  logic [3:0]    code_new;
  logic          res_none, res_single, res_multi;

  // Scan engine: row stepping plus per-scan hit accumulation.
  always_comb begin
    nlow    = 3'd0;
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      nlow = nlow + {2'b00, ~col_in[i]};
      if (!col_in[i]) low_col = 2'(i);
    end

    sample     = active_q && (hold_cnt_q == HOLD_LAST);
    scan_end   = sample && (row_idx_q == 2'd3);
    hits_sum   = {1'b0, hits_q} + (sample ? nlow : 3'd0);
    hits_new   = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_new   = (sample && hits_q == 2'd0 && nlow != 3'd0) ? {row_idx_q, low_col} : code_q;
    res_none   = (hits_new == 2'd0);
    res_single = (hits_new == 2'd1);
    res_multi  = (hits_new == 2'd2);

    hold_cnt_d = hold_cnt_q;
    row_idx_d  = row_idx_q;
    hits_d     = hits_new;
    code_d     = code_new;
    if (active_q) begin
      if (sample) begin
        hold_cnt_d = '0;
        row_idx_d  = row_idx_q + 2'd1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
    if (scan_end) begin
      hits_d = 2'd0;
      code_d = 4'd0;
    end
  end

  // Debounce FSM, stepped only by completed scans.
  always_comb begin
    logic          accept;
    logic [3:0]    accept_code;
    logic [CW-1:0] inc;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    multi_err_d = scan_end && res_multi;
    accept      = 1'b0;
    accept_code = cand_q;
    inc         = '0;

    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (res_single) begin
            cand_d = code_new;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS <= 1) begin
              accept      = 1'b1;
              accept_code = code_new;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (res_single && code_new == cand_q) begin
            inc = (cnt_q < DS) ? cnt_q + 1'b1 : cnt_q;
            if (inc == DS) accept = 1'b1;
            else cnt_d = inc;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (res_none) begin
            inc = (rel_q < DS) ? rel_q + 1'b1 : rel_q;
            if (inc == DS) begin
              key_down_d = 1'b0;
              state_d    = IDLE;
              rel_d      = '0;
            end else begin
              rel_d = inc;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      key_code_d  = accept_code;
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
      state_d     = HELD;
      cnt_d       = '0;
      rel_d       = '0;
    end
  end

  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      active_q    <= 1'b0;
      row_idx_q   <= 2'd0;
      hold_cnt_q  <= '0;
      hits_q      <= 2'd0;
      code_q      <= 4'd0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rel_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      active_q    <= 1'b1;
      row_idx_q   <= row_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      hits_q      <= hits_d;
      code_q      <= code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      multi_err_q <= multi_err_d;
    end
  end

  // Rows stay released during reset; scanning begins the cycle after it lifts.
  assign row       = active_q ? ~(4'b0001 << row_idx_q) : 4'b1111;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign multi_err = multi_err_q;

endmodule
